// File: rtl/kernel_mcu_pkg.sv
// Shared constants and helpers for the MCU-side I/O blocks.
// Counter-width helper keeps debounce sizing consistent across users.
package kernel_mcu_pkg;

  localparam int MCU_IO_WIDTH        = 7;
  localparam int MCU_DEBOUNCE_CYCLES = 16;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/kernel_mcu_debounce_bit.sv
// One conditioned MCU status line: sync, invert, debounce,
// edge pulses and optional sticky rising-edge latch.
module kernel_mcu_debounce_bit
  import kernel_mcu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = MCU_DEBOUNCE_CYCLES,
  parameter bit INVERT          = 1'b0,
  parameter bit STICKY          = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic clr,
  output logic pio,
  output logic rise,
  output logic fall,
  output logic filt
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          latch;
  logic          settle;

  assign settle = (s2 != filt) && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      filt  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      latch <= 1'b0;
    end else begin
      s1   <= raw ^ INVERT;
      s2   <= s1;
      rise <= settle && s2;
      fall <= settle && !s2;
      if (s2 == filt) begin
        cnt <= '0;
      end else if (settle) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // set beats clear so an edge landing on a clear is not lost
      latch <= STICKY && ((latch && !clr) || rise);
    end
  end

  assign pio = STICKY ? (latch | rise) : filt;

endmodule

// File: rtl/kernel_mcu_in_cond.sv
// Input conditioner for the MCU status lines feeding the PIO in_port.
// Each line is handled by an independent debounce_bit instance.
module kernel_mcu_in_cond
  import kernel_mcu_pkg::*;
#(
  parameter int               WIDTH           = MCU_IO_WIDTH,
  parameter int               DEBOUNCE_CYCLES = MCU_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] INVERT_MASK     = '0,
  parameter logic [WIDTH-1:0] STICKY_MASK     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] rise_evt,
  output logic [WIDTH-1:0] fall_evt,
  output logic [WIDTH-1:0] filt_lvl
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    kernel_mcu_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (INVERT_MASK[i]),
      .STICKY         (STICKY_MASK[i])
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_in[i]),
      .clr  (evt_clr[i]),
      .pio  (pio_in[i]),
      .rise (rise_evt[i]),
      .fall (fall_evt[i]),
      .filt (filt_lvl[i])
    );
  end

endmodule

// File: tb/tb_kernel_mcu_in_cond.sv
// Scoreboard bench: stimulus queues expected edge events,
// a negedge monitor pops and compares when a DUT pulses.
module tb_kernel_mcu_in_cond;

  typedef struct {
    int         cyc;
    logic [6:0] rise;
    logic [6:0] fall;
    logic [6:0] filt;
    logic [6:0] pio;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] raw_a, raw_b, clr_a, clr_b;
  logic [6:0] pio_a, rise_a, fall_a, filt_a;
  logic [6:0] pio_b, rise_b, fall_b, filt_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  kernel_mcu_in_cond #(
    .DEBOUNCE_CYCLES(4)
  ) dut_a (
    .clk     (clk),
    .reset   (reset),
    .raw_in  (raw_a),
    .evt_clr (clr_a),
    .pio_in  (pio_a),
    .rise_evt(rise_a),
    .fall_evt(fall_a),
    .filt_lvl(filt_a)
  );

  kernel_mcu_in_cond #(
    .DEBOUNCE_CYCLES(4),
    .INVERT_MASK    (7'h01),
    .STICKY_MASK    (7'h02)
  ) dut_b (
    .clk     (clk),
    .reset   (reset),
    .raw_in  (raw_b),
    .evt_clr (clr_b),
    .pio_in  (pio_b),
    .rise_evt(rise_b),
    .fall_evt(fall_b),
    .filt_lvl(filt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [6:0] act,
                     input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_a(input int c, input logic [6:0] r, input logic [6:0] f,
                        input logic [6:0] l, input logic [6:0] p);
    exp_t e;
    e = '{c, r, f, l, p};
    q_a.push_back(e);
  endtask

  task automatic push_b(input int c, input logic [6:0] r, input logic [6:0] f,
                        input logic [6:0] l, input logic [6:0] p);
    exp_t e;
    e = '{c, r, f, l, p};
    q_b.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
      ea = q_a.pop_front();
      checks++;
      errors++;
      $display("FAIL a_missed exp_cyc=%0d now=%0d", ea.cyc, cyc);
    end
    if ((rise_a | fall_a) != 7'h00) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected cyc=%0d rise=%h fall=%h",
                 cyc, rise_a, fall_a);
      end else begin
        ea = q_a.pop_front();
        if (ea.cyc != cyc || ea.rise !== rise_a || ea.fall !== fall_a ||
            ea.filt !== filt_a || ea.pio !== pio_a) begin
          errors++;
          $display("FAIL a_event got cyc=%0d r=%h f=%h l=%h p=%h exp cyc=%0d r=%h f=%h l=%h p=%h",
                   cyc, rise_a, fall_a, filt_a, pio_a,
                   ea.cyc, ea.rise, ea.fall, ea.filt, ea.pio);
        end
      end
    end
    while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
      eb = q_b.pop_front();
      checks++;
      errors++;
      $display("FAIL b_missed exp_cyc=%0d now=%0d", eb.cyc, cyc);
    end
    if ((rise_b | fall_b) != 7'h00) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected cyc=%0d rise=%h fall=%h",
                 cyc, rise_b, fall_b);
      end else begin
        eb = q_b.pop_front();
        if (eb.cyc != cyc || eb.rise !== rise_b || eb.fall !== fall_b ||
            eb.filt !== filt_b || eb.pio !== pio_b) begin
          errors++;
          $display("FAIL b_event got cyc=%0d r=%h f=%h l=%h p=%h exp cyc=%0d r=%h f=%h l=%h p=%h",
                   cyc, rise_b, fall_b, filt_b, pio_b,
                   eb.cyc, eb.rise, eb.fall, eb.filt, eb.pio);
        end
      end
    end
  end

  initial begin
    int c;
    reset = 1'b1;
    raw_a = 7'h7F;
    raw_b = 7'h01;
    clr_a = 7'h00;
    clr_b = 7'h00;

    // reset with all pins asserted
    tick(3);
    chk("rst_filt_a", filt_a, 7'h00);
    chk("rst_pio_a", pio_a, 7'h00);
    chk("rst_rise_a", rise_a, 7'h00);
    chk("rst_pio_b", pio_b, 7'h00);
    reset = 1'b0;
    c = cyc;
    push_a(c + 6, 7'h7F, 7'h00, 7'h7F, 7'h7F);
    tick(1);
    chk("post_rst_filt_a", filt_a, 7'h00);
    tick(4);
    chk("pre_settle_filt_a", filt_a, 7'h00);
    tick(6);
    c = cyc;
    raw_a = 7'h00;
    push_a(c + 6, 7'h00, 7'h7F, 7'h00, 7'h00);
    tick(10);

    // glitch of 3 samples rejected
    raw_a = 7'h08;
    tick(3);
    raw_a = 7'h00;
    tick(10);
    chk("glitch3_filt", filt_a, 7'h00);
    chk("glitch3_pio", pio_a, 7'h00);

    // 4 samples accepted
    c = cyc;
    raw_a = 7'h08;
    push_a(c + 6, 7'h08, 7'h00, 7'h08, 7'h08);
    push_a(c + 10, 7'h00, 7'h08, 7'h00, 7'h00);
    tick(4);
    raw_a = 7'h00;
    tick(12);

    // bounce on bit 0, then hold high
    for (int k = 0; k < 10; k++) begin
      raw_a = (k % 2 == 0) ? 7'h01 : 7'h00;
      tick(2);
    end
    c = cyc;
    raw_a = 7'h01;
    push_a(c + 6, 7'h01, 7'h00, 7'h01, 7'h01);
    tick(12);
    c = cyc;
    raw_a = 7'h00;
    push_a(c + 6, 7'h00, 7'h01, 7'h00, 7'h00);
    tick(10);

    // inverted bit 0 on dut_b
    chk("inv_idle_filt_b", filt_b, 7'h00);
    c = cyc;
    raw_b = 7'h00;
    push_b(c + 6, 7'h01, 7'h00, 7'h01, 7'h01);
    tick(10);
    c = cyc;
    raw_b = 7'h01;
    push_b(c + 6, 7'h00, 7'h01, 7'h00, 7'h00);
    tick(10);

    // sticky bit 1 on dut_b
    c = cyc;
    raw_b = 7'h03;
    push_b(c + 6, 7'h02, 7'h00, 7'h02, 7'h02);
    tick(8);
    c = cyc;
    raw_b = 7'h01;
    push_b(c + 6, 7'h00, 7'h02, 7'h00, 7'h02);
    tick(10);
    chk("sticky_hold_pio_b", pio_b, 7'h02);
    chk("sticky_hold_filt_b", filt_b, 7'h00);
    clr_b = 7'h02;
    tick(1);
    clr_b = 7'h00;
    chk("sticky_clr_pio_b", pio_b, 7'h00);
    tick(3);

    // clear coincident with rise: set wins
    c = cyc;
    raw_b = 7'h03;
    push_b(c + 6, 7'h02, 7'h00, 7'h02, 7'h02);
    tick(6);
    clr_b = 7'h02;
    tick(1);
    clr_b = 7'h00;
    chk("set_wins_pio_b", pio_b, 7'h02);
    c = cyc;
    raw_b = 7'h01;
    push_b(c + 6, 7'h00, 7'h02, 7'h00, 7'h02);
    tick(10);

    // reset in the middle of a debounce on bit 5
    raw_a = 7'h20;
    tick(4);
    reset = 1'b1;
    tick(2);
    chk("mid_rst_filt_a", filt_a, 7'h00);
    chk("mid_rst_pio_b", pio_b, 7'h00);
    reset = 1'b0;
    c = cyc;
    push_a(c + 6, 7'h20, 7'h00, 7'h20, 7'h20);
    tick(5);
    chk("mid_rst_pre_filt_a", filt_a, 7'h00);
    tick(6);
    c = cyc;
    raw_a = 7'h00;
    push_a(c + 6, 7'h00, 7'h20, 7'h00, 7'h00);
    tick(10);

    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left_a=%0d left_b=%0d exp=0",
               q_a.size(), q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
